// File: rtl/psum_acc_ctrl.sv
// rtl/psum_acc_ctrl.sv - OFIFO drain and multi-pass psum accumulate into single-port SRAM
module psum_acc_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int NPASS   = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   relu_en,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] psum_in,
    output logic                   ofifo_rd,
    output logic                   mem_cen,
    output logic                   mem_wen,
    output logic [AW-1:0]          mem_addr,
    output logic [psum_bw*col-1:0] mem_d,
    input  logic [psum_bw*col-1:0] mem_q,
    output logic                   busy,
    output logic                   done
);
    localparam int W  = psum_bw * col;
    localparam int PW = $clog2(NPASS + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WR0, S_RDM, S_ACC, S_DONE} state_t;

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [PW-1:0]   pass_q;
    logic            relu_q;
    logic [W-1:0]    hold_q;
    logic            mem_cen_q;
    logic            mem_wen_q;
    logic [W-1:0]    mem_d_q;
    logic            busy_q;
    logic            done_q;

    logic            last_pass;
    logic [W-1:0]    wr0_d;
    logic [W-1:0]    acc_d;

    assign last_pass = (pass_q == PW'(NPASS - 1));

    // Lane-wise add without inter-lane carry; ReLU only on the final pass.
    always_comb begin
        wr0_d = psum_in;
        acc_d = '0;
        for (int i = 0; i < col; i++) begin
            acc_d[i*psum_bw +: psum_bw] = hold_q[i*psum_bw +: psum_bw] + mem_q[i*psum_bw +: psum_bw];
            if (relu_q && last_pass) begin
                if (wr0_d[(i+1)*psum_bw-1]) wr0_d[i*psum_bw +: psum_bw] = '0;
                if (acc_d[(i+1)*psum_bw-1]) acc_d[i*psum_bw +: psum_bw] = '0;
            end
        end
    end

    // Reset gates the pop and the chip enable so an in-flight write is dropped.
    assign ofifo_rd = (state_q == S_WAIT) && ofifo_valid && !reset;
    assign mem_cen  = mem_cen_q | reset;
    assign mem_wen  = mem_wen_q;
    assign mem_addr = addr_q;
    assign mem_d    = (state_q == S_ACC) ? acc_d : mem_d_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            pass_q    <= '0;
            relu_q    <= 1'b0;
            hold_q    <= '0;
            mem_cen_q <= 1'b1;
            mem_wen_q <= 1'b1;
            mem_d_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        relu_q  <= relu_en;
                        addr_q  <= '0;
                        pass_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ofifo_valid) begin
                        hold_q    <= psum_in;
                        mem_cen_q <= 1'b0;
                        if (pass_q == '0) begin
                            mem_wen_q <= 1'b0;
                            mem_d_q   <= wr0_d;
                            state_q   <= S_WR0;
                        end else begin
                            mem_wen_q <= 1'b1;
                            state_q   <= S_RDM;
                        end
                    end
                end
                S_RDM: begin
                    mem_wen_q <= 1'b0;
                    state_q   <= S_ACC;
                end
                S_WR0, S_ACC: begin
                    if (state_q == S_ACC) mem_d_q <= acc_d;
                    mem_cen_q <= 1'b1;
                    mem_wen_q <= 1'b1;
                    if (addr_q == AW'(DEPTH - 1)) begin
                        addr_q <= '0;
                        pass_q <= pass_q + PW'(1);
                        if (last_pass) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else begin
                        addr_q  <= addr_q + AW'(1);
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_acc_ctrl.sv
// tb/tb_psum_acc_ctrl.sv - self-checking bench for psum_acc_ctrl with SRAM/OFIFO models
module tb_psum_acc_ctrl;
    localparam int COL    = 4;
    localparam int BW     = 16;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;
    localparam int NPASS  = 3;
    localparam int W      = COL * BW;
    localparam int JOBLEN = DEPTH * (2 + 3 * (NPASS - 1));
    localparam int BUDGET = 300;

    logic          clk;
    logic          reset;
    logic          start;
    logic          relu_en;
    logic          ofifo_valid;
    logic [W-1:0]  psum_in;
    logic          ofifo_rd;
    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_d;
    logic [W-1:0]  mem_q;
    logic          busy;
    logic          done;

    psum_acc_ctrl #(.col(COL), .psum_bw(BW), .DEPTH(DEPTH), .AW(AW), .NPASS(NPASS)) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .ofifo_valid(ofifo_valid), .psum_in(psum_in), .ofifo_rd(ofifo_rd),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_d(mem_d),
        .mem_q(mem_q), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    int done_cnt = 0;

    // Single-port SRAM model
    logic [W-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) sram[mem_addr] <= mem_d;
            else          mem_q <= sram[mem_addr];
        end
    end

    // Show-ahead OFIFO model
    logic [W-1:0] fq [1024];
    logic [9:0]   wr_ptr = '0;
    logic [9:0]   rd_ptr = '0;
    logic         stall;
    assign ofifo_valid = (wr_ptr != rd_ptr) && !stall;
    assign psum_in     = fq[rd_ptr];
    always @(posedge clk) if (ofifo_rd) rd_ptr <= rd_ptr + 10'd1;

    always @(negedge clk) begin
        if (ofifo_rd) pops++;
        if (done) done_cnt++;
        n_checks++;
        assert (!(ofifo_rd && !ofifo_valid)) else begin
            n_fail++;
            $error("FAIL pop_empty observed rd=%0b valid=%0b expected no pop", ofifo_rd, ofifo_valid);
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] vec [NPASS][DEPTH];

    task automatic gen_vec(input int mode);
        logic [BW-1:0] v;
        for (int p = 0; p < NPASS; p++)
            for (int a = 0; a < DEPTH; a++)
                for (int l = 0; l < COL; l++) begin
                    case (mode)
                        1: v = (p == 0) ? 16'd5 : (p == 1) ? 16'd7 : 16'd0;
                        2: v = (l == 0) ? ((p == 0) ? 16'h7FFF : (p == 1) ? 16'h0001 : 16'h0000) : 16'h0001;
                        3: v = (l == 0) ? 16'hFFFF : (l == 1) ? 16'd10 : (l == 2) ? 16'($urandom) : 16'd0;
                        default: v = 16'($urandom);
                    endcase
                    vec[p][a][l*BW +: BW] = v;
                end
    endtask

    task automatic push_vec();
        for (int p = 0; p < NPASS; p++)
            for (int a = 0; a < DEPTH; a++) begin
                fq[wr_ptr] = vec[p][a];
                wr_ptr = wr_ptr + 10'd1;
            end
    endtask

    task automatic run_job(input logic relu, input bit do_stall, input bit pulse_mid);
        int cycles;
        int pops0;
        int done0;
        logic [W-1:0] exp_w;
        int s;
        logic [BW-1:0] t;
        start   = 1'b1;
        relu_en = relu;
        @(posedge clk); #1;
        start   = 1'b0;
        relu_en = !relu;
        pops0   = pops;
        done0   = done_cnt;
        cycles  = 0;
        while (!done && cycles < BUDGET) begin
            start = pulse_mid && (cycles == 5);
            stall = do_stall && (cycles >= 10) && (cycles < 20);
            @(posedge clk); #1;
            cycles++;
            if (do_stall && cycles >= 13 && cycles <= 20) begin
                check("stall_cen", W'(mem_cen), W'(1'b1));
                check("stall_rd", W'(ofifo_rd), W'(1'b0));
            end
        end
        start = 1'b0;
        stall = 1'b0;
        check("job_done_seen", W'(done), W'(1'b1));
        if (!do_stall) check("job_cycles", W'(cycles), W'(JOBLEN));
        @(posedge clk); #1;
        check("done_one_cycle", W'(done), W'(1'b0));
        check("busy_after", W'(busy), W'(1'b0));
        check("pop_count", W'(pops - pops0), W'(DEPTH * NPASS));
        check("done_count", W'(done_cnt - done0), W'(1));
        for (int a = 0; a < DEPTH; a++) begin
            for (int l = 0; l < COL; l++) begin
                s = 0;
                for (int p = 0; p < NPASS; p++) s += int'($signed(vec[p][a][l*BW +: BW]));
                t = s[BW-1:0];
                if (relu && t[BW-1]) t = '0;
                exp_w[l*BW +: BW] = t;
            end
            check("mem_word", sram[a], exp_w);
        end
        repeat (3) @(posedge clk);
        #1;
        check("stays_idle", W'(busy), W'(1'b0));
    endtask

    logic [W-1:0] snap;

    initial begin
        reset = 1'b1; start = 1'b0; relu_en = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", W'(ofifo_rd), W'(1'b0));
        check("rst_cen", W'(mem_cen), W'(1'b1));
        check("rst_wen", W'(mem_wen), W'(1'b1));
        check("rst_addr", W'(mem_addr), W'(0));
        check("rst_d", mem_d, W'(0));
        check("rst_busy", W'(busy), W'(1'b0));
        check("rst_done", W'(done), W'(1'b0));
        reset = 1'b0;
        @(posedge clk); #1;

        gen_vec(1); push_vec(); run_job(1'b0, 1'b0, 1'b0);
        check("const_sum_a0", sram[0], 64'h000C_000C_000C_000C);
        check("const_sum_a1", sram[1], 64'h000C_000C_000C_000C);

        gen_vec(2); push_vec(); run_job(1'b0, 1'b0, 1'b0);
        check("wrap_lane0", W'(sram[0][15:0]), W'(16'h8000));
        check("wrap_lane1", W'(sram[0][31:16]), W'(16'h0003));

        gen_vec(3); push_vec(); run_job(1'b1, 1'b0, 1'b0);
        check("relu_neg", W'(sram[2][15:0]), W'(16'h0000));
        check("relu_pos", W'(sram[2][31:16]), W'(16'd30));
        push_vec(); run_job(1'b0, 1'b0, 1'b0);
        check("norelu_neg", W'(sram[2][15:0]), W'(16'hFFFD));

        gen_vec(0); push_vec(); run_job(1'b0, 1'b1, 1'b0);
        gen_vec(0); push_vec(); run_job(1'b1, 1'b0, 1'b1);

        // Abort during the first ACC of pass 1
        gen_vec(0); push_vec();
        start = 1'b1; relu_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("in_acc_cen", W'(mem_cen), W'(1'b0));
        check("in_acc_wen", W'(mem_wen), W'(1'b0));
        snap  = sram[0];
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_cen", W'(mem_cen), W'(1'b1));
        check("midrst_wen", W'(mem_wen), W'(1'b1));
        check("midrst_rd", W'(ofifo_rd), W'(1'b0));
        check("midrst_addr", W'(mem_addr), W'(0));
        check("midrst_d", mem_d, W'(0));
        check("midrst_busy", W'(busy), W'(1'b0));
        check("midrst_done", W'(done), W'(1'b0));
        check("midrst_nowrite", sram[0], snap);
        reset  = 1'b0;
        wr_ptr = rd_ptr;
        @(posedge clk); #1;
        gen_vec(0); push_vec(); run_job(1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 2; j++) begin
            gen_vec(0); push_vec(); run_job(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
